// File: rtl/motor_link_interlock_pkg.sv
// Shared motor-control definitions for the GBT RX side of the application.
// Holds the clock/reset bundle, link state encoding and interlock constants.
package MCPkg;

    typedef struct packed {
        logic clk;
        logic reset;
    } ckrs_t;

    typedef enum logic [1:0] {
        SAFE   = 2'd0,
        ARMING = 2'd1,
        ACTIVE = 2'd2,
        FAULT  = 2'd3
    } link_state_t;

    localparam logic [31:0] GEFE_INTERLOCK  = 32'h6EFE_C10D;
    localparam int unsigned MOTOR_CTRL_BITS = 4;
    localparam logic [MOTOR_CTRL_BITS-1:0] MOTOR_SAFE_WORD = '1;

endpackage

// File: rtl/motor_link_interlock_frame_watchdog.sv
// Counts enabled frames without a kick; expired_o flags the frame that reaches G_TIMEOUT.
// expired_o is combinational so the owner can act on the same edge.
module frame_watchdog
    import MCPkg::*;
#(
    parameter int unsigned G_TIMEOUT = 4000
) (
    input  ckrs_t ClkRs_ix,
    input  logic  enable_i,
    input  logic  clear_i,
    input  logic  kick_i,
    output logic  expired_o
);

    localparam int unsigned CNT_W = $clog2(G_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(G_TIMEOUT - 1);

    logic             clk;
    logic             rst;
    logic [CNT_W-1:0] cnt_r;

    assign clk = ClkRs_ix.clk;
    assign rst = ClkRs_ix.reset;

    assign expired_o = enable_i && !clear_i && !kick_i && (cnt_r == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= '0;
        end else if (clear_i) begin
            cnt_r <= '0;
        end else if (enable_i) begin
            // Restart on expiry so the counter can never wrap.
            if (kick_i || expired_o)
                cnt_r <= '0;
            else
                cnt_r <= cnt_r + CNT_W'(1);
        end
    end

endmodule

// File: rtl/motor_link_interlock.sv
// Gates GBT-received motor control words onto the driver pins behind a loop-closed
// interlock and a frame watchdog; any link loss forces safe words until re-armed.
module motor_link_interlock
    import MCPkg::*;
#(
    parameter int unsigned G_MOTORS         = 16,
    parameter int unsigned G_CTRL_BITS      = MOTOR_CTRL_BITS,
    parameter logic [G_CTRL_BITS-1:0] G_SAFE_WORD = '1,
    parameter logic [31:0] G_INTERLOCK_KEY  = GEFE_INTERLOCK,
    parameter int unsigned G_ARM_FRAMES     = 8,
    parameter int unsigned G_TIMEOUT_FRAMES = 4000
) (
    input  ckrs_t                             ClkRs_ix,
    input  logic                              enable_i,
    input  logic                              data_valid_i,
    input  logic [31:0]                       feedback_ib32,
    input  logic [G_MOTORS*G_CTRL_BITS-1:0]   ctrl_ib,
    input  logic [G_MOTORS-1:0]               motor_mask_ib,
    input  logic                              rearm_i,
    output logic [G_MOTORS*G_CTRL_BITS-1:0]   ctrl_ob,
    output logic [1:0]                        state_ob,
    output logic                              active_o,
    output logic                              fault_o,
    output logic [15:0]                       drop_count_ob
);

    localparam int unsigned W     = G_MOTORS * G_CTRL_BITS;
    localparam int unsigned ARM_W = $clog2(G_ARM_FRAMES + 1);
    localparam logic [ARM_W-1:0] ARM_LAST = ARM_W'(G_ARM_FRAMES - 1);
    localparam logic [W-1:0] SAFE_VEC = {G_MOTORS{G_SAFE_WORD}};

    logic             clk;
    logic             rst;
    logic             match;
    logic             wd_clear;
    logic             wd_expired;
    link_state_t      state_r;
    link_state_t      state_nxt;
    logic [ARM_W-1:0] arm_r;
    logic [ARM_W-1:0] arm_nxt;
    logic [W-1:0]     cap_r;
    logic [W-1:0]     cap_nxt;
    logic [W-1:0]     ctrl_r;
    logic [W-1:0]     ctrl_nxt;
    logic             drop_inc;
    logic [15:0]      drop_cnt_r;
    logic             active_r;
    logic             fault_r;

    assign clk   = ClkRs_ix.clk;
    assign rst   = ClkRs_ix.reset;
    assign match = (feedback_ib32 == G_INTERLOCK_KEY);

    // Watchdog sits at zero outside ACTIVE, so entering ACTIVE always starts it fresh.
    assign wd_clear = (state_r != ACTIVE);

    frame_watchdog #(
        .G_TIMEOUT (G_TIMEOUT_FRAMES)
    ) u_frame_watchdog (
        .ClkRs_ix  (ClkRs_ix),
        .enable_i  (enable_i),
        .clear_i   (wd_clear),
        .kick_i    (data_valid_i),
        .expired_o (wd_expired)
    );

    always_comb begin
        state_nxt = state_r;
        arm_nxt   = arm_r;
        cap_nxt   = cap_r;
        drop_inc  = 1'b0;
        case (state_r)
            SAFE: begin
                if (enable_i && match) begin
                    if (G_ARM_FRAMES == 1) begin
                        state_nxt = ACTIVE;
                        cap_nxt   = SAFE_VEC;
                    end else begin
                        state_nxt = ARMING;
                        arm_nxt   = ARM_W'(1);
                    end
                end
            end
            ARMING: begin
                if (enable_i) begin
                    if (!match) begin
                        state_nxt = SAFE;
                        arm_nxt   = '0;
                    end else if (arm_r == ARM_LAST) begin
                        state_nxt = ACTIVE;
                        arm_nxt   = '0;
                        cap_nxt   = SAFE_VEC;
                    end else begin
                        arm_nxt = arm_r + ARM_W'(1);
                    end
                end
            end
            ACTIVE: begin
                if (enable_i) begin
                    if (!match) begin
                        state_nxt = FAULT;
                        drop_inc  = 1'b1;
                    end else if (data_valid_i) begin
                        cap_nxt = ctrl_ib;
                    end else if (wd_expired) begin
                        state_nxt = FAULT;
                        drop_inc  = 1'b1;
                    end
                end
            end
            FAULT: begin
                if (rearm_i)
                    state_nxt = SAFE;
            end
            default: state_nxt = SAFE;
        endcase
    end

    always_comb begin
        ctrl_nxt = SAFE_VEC;
        for (int unsigned m = 0; m < G_MOTORS; m++) begin
            if (state_nxt == ACTIVE && motor_mask_ib[m])
                ctrl_nxt[m*G_CTRL_BITS +: G_CTRL_BITS] = cap_nxt[m*G_CTRL_BITS +: G_CTRL_BITS];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= SAFE;
            arm_r      <= '0;
            cap_r      <= SAFE_VEC;
            ctrl_r     <= SAFE_VEC;
            drop_cnt_r <= '0;
            active_r   <= 1'b0;
            fault_r    <= 1'b0;
        end else begin
            state_r  <= state_nxt;
            arm_r    <= arm_nxt;
            cap_r    <= cap_nxt;
            ctrl_r   <= ctrl_nxt;
            active_r <= (state_nxt == ACTIVE);
            fault_r  <= (state_nxt == FAULT);
            if (drop_inc && (drop_cnt_r != '1))
                drop_cnt_r <= drop_cnt_r + 16'd1;
        end
    end

    assign ctrl_ob       = ctrl_r;
    assign state_ob      = state_r;
    assign active_o      = active_r;
    assign fault_o       = fault_r;
    assign drop_count_ob = drop_cnt_r;

endmodule

// File: tb/tb_motor_link_interlock.sv
// Directed bench for motor_link_interlock with 4 motors, 3 arming frames, 5-frame timeout.
module tb_motor_link_interlock;
    import MCPkg::*;

    localparam logic [31:0] KEY = GEFE_INTERLOCK;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    ckrs_t       gbt_rx_clkrs;
    logic        enable_i = 1'b1;
    logic        data_valid_i = 1'b0;
    logic [31:0] feedback_ib32 = '0;
    logic [15:0] ctrl_ib = '0;
    logic [3:0]  motor_mask_ib = 4'hF;
    logic        rearm_i = 1'b0;
    logic [15:0] ctrl_ob;
    logic [1:0]  state_ob;
    logic        active_o;
    logic        fault_o;
    logic [15:0] drop_count_ob;

    int unsigned n_checks = 0;
    int unsigned n_fails  = 0;

    assign gbt_rx_clkrs.clk   = clk;
    assign gbt_rx_clkrs.reset = rst;

    always #5 clk = ~clk;

    motor_link_interlock #(
        .G_MOTORS         (4),
        .G_CTRL_BITS      (4),
        .G_SAFE_WORD      (4'hF),
        .G_INTERLOCK_KEY  (KEY),
        .G_ARM_FRAMES     (3),
        .G_TIMEOUT_FRAMES (5)
    ) dut (
        .ClkRs_ix      (gbt_rx_clkrs),
        .enable_i      (enable_i),
        .data_valid_i  (data_valid_i),
        .feedback_ib32 (feedback_ib32),
        .ctrl_ib       (ctrl_ib),
        .motor_mask_ib (motor_mask_ib),
        .rearm_i       (rearm_i),
        .ctrl_ob       (ctrl_ob),
        .state_ob      (state_ob),
        .active_o      (active_o),
        .fault_o       (fault_o),
        .drop_count_ob (drop_count_ob)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic arm_up();
        feedback_ib32 = KEY;
        repeat (3) tick();
    endtask

    task automatic do_rearm();
        rearm_i = 1'b1;
        tick();
        rearm_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL bench_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        #12;
        check("rst_state",  32'(state_ob), 32'd0);
        check("rst_ctrl",   32'(ctrl_ob), 32'hFFFF);
        check("rst_active", 32'(active_o), 32'd0);
        check("rst_fault",  32'(fault_o), 32'd0);
        check("rst_drop",   32'(drop_count_ob), 32'd0);
        rst = 1'b0;

        // Arming aborted by a mismatch on the third frame
        feedback_ib32 = KEY;
        tick(); check("abort_st1", 32'(state_ob), 32'd1);
        tick(); check("abort_st2", 32'(state_ob), 32'd1);
        feedback_ib32 = 32'h0;
        tick(); check("abort_safe", 32'(state_ob), 32'd0);
        check("abort_drop", 32'(drop_count_ob), 32'd0);
        check("abort_ctrl", 32'(ctrl_ob), 32'hFFFF);

        // Full arming sequence
        feedback_ib32 = KEY;
        tick(); check("arm_st1", 32'(state_ob), 32'd1);
        tick(); check("arm_st2", 32'(state_ob), 32'd1);
        check("arm_ctrl_safe", 32'(ctrl_ob), 32'hFFFF);
        tick(); check("arm_active", 32'(state_ob), 32'd2);
        check("arm_active_o", 32'(active_o), 32'd1);
        check("arm_no_stale", 32'(ctrl_ob), 32'hFFFF);
        data_valid_i = 1'b1; ctrl_ib = 16'h1234;
        tick(); check("cap_1234", 32'(ctrl_ob), 32'h1234);

        // Mask
        motor_mask_ib = 4'b0101;
        tick(); check("mask_0101", 32'(ctrl_ob), 32'hF2F4);
        motor_mask_ib = 4'hF;
        data_valid_i = 1'b0;

        // Watchdog: fault on the fifth frame without data
        repeat (4) tick();
        check("wd_4_state", 32'(state_ob), 32'd2);
        check("wd_4_ctrl",  32'(ctrl_ob), 32'h1234);
        tick();
        check("wd_5_state", 32'(state_ob), 32'd3);
        check("wd_5_ctrl",  32'(ctrl_ob), 32'hFFFF);
        check("wd_5_fault", 32'(fault_o), 32'd1);
        check("wd_5_active", 32'(active_o), 32'd0);
        check("wd_5_drop",  32'(drop_count_ob), 32'd1);

        // FAULT ignores key and data until rearm
        data_valid_i = 1'b1; ctrl_ib = 16'h5678;
        repeat (2) tick();
        check("fault_hold_st", 32'(state_ob), 32'd3);
        check("fault_hold_ctrl", 32'(ctrl_ob), 32'hFFFF);
        data_valid_i = 1'b0;
        do_rearm();
        check("rearm_safe", 32'(state_ob), 32'd0);
        check("rearm_fault_o", 32'(fault_o), 32'd0);
        tick(); check("rearm_arm1", 32'(state_ob), 32'd1);
        tick(); check("rearm_arm2", 32'(state_ob), 32'd1);
        tick(); check("rearm_active", 32'(state_ob), 32'd2);

        // Enable toggling; key absent on disabled frames must be ignored
        for (int i = 0; i < 10; i++) begin
            enable_i = (i % 2) == 1;
            feedback_ib32 = enable_i ? KEY : 32'h0;
            tick();
            if (i == 8) check("en_9clk_state", 32'(state_ob), 32'd2);
        end
        check("en_10clk_state", 32'(state_ob), 32'd3);
        check("en_10clk_ctrl", 32'(ctrl_ob), 32'hFFFF);
        check("en_10clk_drop", 32'(drop_count_ob), 32'd2);
        enable_i = 1'b1;

        // Mismatch together with data_valid
        do_rearm();
        arm_up();
        data_valid_i = 1'b1; ctrl_ib = 16'hABCD;
        tick(); check("cap_abcd", 32'(ctrl_ob), 32'hABCD);
        feedback_ib32 = 32'h0; ctrl_ib = 16'h5555;
        tick();
        check("mm_dv_state", 32'(state_ob), 32'd3);
        check("mm_dv_ctrl", 32'(ctrl_ob), 32'hFFFF);
        check("mm_dv_drop", 32'(drop_count_ob), 32'd3);
        data_valid_i = 1'b0;

        // Saturation of the drop counter
        do_rearm();
        arm_up();
        force dut.drop_cnt_r = 16'hFFFE;
        #1;
        release dut.drop_cnt_r;
        feedback_ib32 = 32'h0;
        tick(); check("sat_ffff", 32'(drop_count_ob), 32'hFFFF);
        do_rearm();
        arm_up();
        feedback_ib32 = 32'h0;
        tick();
        check("sat_state", 32'(state_ob), 32'd3);
        check("sat_hold", 32'(drop_count_ob), 32'hFFFF);

        // Asynchronous reset while ACTIVE
        do_rearm();
        arm_up();
        data_valid_i = 1'b1; ctrl_ib = 16'h1234;
        tick(); check("pre_rst_ctrl", 32'(ctrl_ob), 32'h1234);
        #2;
        rst = 1'b1;
        #1;
        check("arst_state", 32'(state_ob), 32'd0);
        check("arst_ctrl", 32'(ctrl_ob), 32'hFFFF);
        check("arst_active", 32'(active_o), 32'd0);
        check("arst_fault", 32'(fault_o), 32'd0);
        check("arst_drop", 32'(drop_count_ob), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/motor_link_interlock.md
Name: motor_link_interlock

Overview:
- Parametrised successor to the fixed GBT-to-motor interlock in the application top level.
- Gates N motor control words from the GBT RX stream onto the driver pins.
- Requires a sustained loop-closed condition (serial feedback word equals interlock key) before arming, and a frame watchdog while active.
- On loss of link, stale data or a key mismatch: all motors forced to the safe (deactivated) word and a latched fault is held until an explicit re-arm. Sits in the gbt_rx_clkrs domain between the GBT decoder and the motor pin mapping.

Parameters:
G_MOTORS, 16, number of motor channels
G_CTRL_BITS, 4, control bits per motor
G_SAFE_WORD, '1 (G_CTRL_BITS wide), per-motor safe value; all ones asserts StepDeactivate
G_INTERLOCK_KEY, GEFE_INTERLOCK, 32-bit feedback value meaning loop closed
G_ARM_FRAMES, 8, consecutive matching enabled frames needed to go ACTIVE (>=1)
G_TIMEOUT_FRAMES, 4000, enabled frames without data_valid_i before fault (>=1)

Ports:
ClkRs_ix  input  ckrs_t  .clk frame clock; .reset asynchronous, active-high
enable_i  input  1  frame clock enable (rx_clken); all evaluation happens only when high
data_valid_i  input  1  current frame carries valid control data
feedback_ib32  input  32  feedback word from serial register loopback
ctrl_ib  input  G_MOTORS*G_CTRL_BITS  received control words, motor 0 in LSBs
motor_mask_ib  input  G_MOTORS  1 = motor allowed to follow control data
rearm_i  input  1  single-cycle pulse; leaves FAULT
ctrl_ob  output  G_MOTORS*G_CTRL_BITS  gated control words (registered)
state_ob  output  2  0 SAFE, 1 ARMING, 2 ACTIVE, 3 FAULT
active_o  output  1  state == ACTIVE
fault_o  output  1  state == FAULT
drop_count_ob  output  16  saturating count of ACTIVE->FAULT transitions

Behaviour:
- Reset (async): state SAFE; ctrl_ob = G_SAFE_WORD replicated; arm/watchdog counters 0; capture register = safe; drop_count_ob 0; active_o 0; fault_o 0.
- match = (feedback_ib32 == G_INTERLOCK_KEY), combinational, sampled only when enable_i=1. With enable_i=0 all state, counters and the capture register hold.
- SAFE: on enable & match -> ARMING with arm_cnt=1. If G_ARM_FRAMES==1 -> ACTIVE directly.
- ARMING: on enable & match -> arm_cnt+1; reaching G_ARM_FRAMES -> ACTIVE. On enable & !match -> SAFE, arm_cnt=0. ARMING never faults.
- Entering ACTIVE: capture register loaded with safe word, watchdog = 0. No stale data passes; a fresh data_valid frame is required.
- ACTIVE, per enabled frame, in priority order:
  - !match -> FAULT.
  - data_valid_i -> capture ctrl_ib, watchdog = 0.
  - otherwise watchdog+1; reaching G_TIMEOUT_FRAMES -> FAULT.
- Every ACTIVE->FAULT transition increments drop_count_ob by exactly one, saturating at 16'hFFFF. Cleared only by reset.
- Mismatch and data_valid_i in the same frame: FAULT, data not captured.
- FAULT: rearm_i (any cycle, enable not required) -> SAFE; arming must then be redone. rearm_i in any other state is ignored.
- ctrl_ob register is computed from next-state and next-capture values:
  - Per motor: captured word if next state is ACTIVE and motor_mask_ib bit = 1; else G_SAFE_WORD.
  - Capture at edge N appears on ctrl_ob after edge N (1-clock latency from input sample).
  - Entering FAULT forces safe on the same edge.
  - Mask changes take effect after one clock.
- state_ob, active_o and fault_o are registered, consistent with ctrl_ob on every cycle.
- Counter widths: $clog2(G_ARM_FRAMES+1) and $clog2(G_TIMEOUT_FRAMES+1); no wrap is possible because state changes at the terminal count.

Decomposition:
- Shared package (MCPkg):
  - link_state_t enum {SAFE, ARMING, ACTIVE, FAULT}
  - GEFE_INTERLOCK (existing)
  - MOTOR_SAFE_WORD constant
  - MOTOR_CTRL_BITS constant
- Sub-module frame_watchdog:
  - Parameter G_TIMEOUT.
  - Ports: ClkRs_ix, enable_i, clear_i, kick_i, expired_o.
  - Reused for other link-loss detectors.

Test Plan (G_MOTORS=4, G_ARM_FRAMES=3, G_TIMEOUT_FRAMES=5, enable_i=1 continuously unless stated):
- Reset, then key present 3 frames -> state_ob 0,1,1 then 2; ctrl_ob = 16'hFFFF until first data_valid frame; data_valid with ctrl_ib=16'h1234 -> ctrl_ob=16'h1234 one clock later.
- Key present 2 frames, mismatch on 3rd -> state back to SAFE, drop_count_ob stays 0, ctrl_ob stays 16'hFFFF.
- ACTIVE, no data_valid for 5 frames -> FAULT on 5th edge, ctrl_ob=16'hFFFF same edge, fault_o=1, drop_count_ob=1; further key/data ignored until rearm_i; rearm_i -> SAFE, re-arming needs 3 frames.
- ACTIVE, motor_mask_ib=4'b0101, ctrl_ib=16'h1234 -> ctrl_ob=16'hF2F4.
- ACTIVE, enable_i toggling 1/0 with no data_valid -> FAULT after 5 enabled frames (10 clocks); mismatch together with data_valid -> FAULT, ctrl_ob safe, no capture.
- Force 65536 fault cycles -> drop_count_ob saturates at 16'hFFFF. Assert reset mid-ACTIVE -> outputs immediately at reset values.
